// File: rtl/mic_pkg.sv
// Shared MIC packet definitions: command encodings, header field positions,
// completer FSM states and the response-header builder.
package mic_pkg;

    localparam int MIC_ADDR_LSB = 0;
    localparam int MIC_LEN_LSB  = 32;
    localparam int MIC_CMD_LSB  = 40;
    localparam int MIC_SRC_LSB  = 44;

    typedef enum logic [1:0] {
        CMD_RD_REQ  = 2'b00,
        CMD_WR_REQ  = 2'b01,
        CMD_RD_RESP = 2'b10,
        CMD_WR_ACK  = 2'b11
    } mic_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_WR_ACK  = 3'd3,
        ST_RD_RUN  = 3'd4
    } mic_state_e;

    // Bits outside the ADDR/LEN/CMD/SRC fields are always zero in a built header.
    function automatic logic [63:0] mic_build_hdr(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input mic_cmd_e    cmd,
        input logic [3:0]  src
    );
        logic [63:0] hdr;
        hdr = '0;
        hdr[MIC_ADDR_LSB +: 32] = addr;
        hdr[MIC_LEN_LSB  +: 8]  = len;
        hdr[MIC_CMD_LSB  +: 2]  = cmd;
        hdr[MIC_SRC_LSB  +: 4]  = src;
        return hdr;
    endfunction

endpackage

// File: rtl/mic_skid2.sv
// Two-entry response buffer (64-bit data + last). The head entry is the
// registered output, so O_TDATA/O_TLAST only move on a pop or when empty.
module mic_skid2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic [63:0] i_data,
    input  logic        i_last,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic        o_last,
    output logic [1:0]  o_count
);

    logic [64:0] r_head;
    logic [64:0] r_tail;
    logic [1:0]  r_count;
    logic        w_pop;
    logic [64:0] w_in;

    assign w_pop = (r_count != 2'd0) && i_ready;
    assign w_in  = {i_last, i_data};

    // Producers only push when a slot is free, so the count never exceeds 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_in;
                    else                 r_tail <= w_in;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= w_in;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head[63:0];
    assign o_last  = r_head[64];
    assign o_count = r_count;

endmodule

// File: rtl/mic_sram_completer.sv
// MIC completer endpoint: services read/write request packets one at a time
// against an internal single-port SRAM and returns response packets.
module mic_sram_completer #(
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        I_TVALID,
    output logic        I_TREADY,
    input  logic [63:0] I_TDATA,
    input  logic        I_TLAST,
    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic [63:0] O_TDATA,
    output logic        O_TLAST
);
    import mic_pkg::*;

    logic [63:0] r_mem [0:(1 << ADDR_WIDTH) - 1];

    mic_state_e r_state, w_state_nxt;
    mic_state_e r_drain_ret, w_drain_ret_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [7:0]  r_len, w_len_nxt;
    logic [3:0]  r_src, w_src_nxt;
    logic [8:0]  r_cnt, w_cnt_nxt;
    logic        r_hdr_sent, w_hdr_sent_nxt;
    logic        r_rd_valid;
    logic        r_rd_last;
    logic [63:0] r_rdata;

    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_we;
    logic                  w_re;
    logic                  w_re_last;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_hdr_push;
    logic                  w_fsm_push;
    logic [63:0]           w_fsm_data;
    logic                  w_fsm_last;
    logic                  w_push;
    logic [63:0]           w_push_data;
    logic                  w_push_last;
    logic [1:0]            w_count;
    logic                  w_pop;
    logic                  w_can_push;
    logic [2:0]            w_occ;

    assign w_in_ready = !reset &&
                        (r_state == ST_IDLE || r_state == ST_WR_DATA || r_state == ST_DRAIN);
    assign I_TREADY   = w_in_ready;
    assign w_in_fire  = I_TVALID && w_in_ready;

    assign w_pop      = O_TVALID && O_TREADY;
    assign w_can_push = (w_count != 2'd2) || w_pop;
    assign w_mem_addr = r_addr[ADDR_WIDTH+2:3] + ADDR_WIDTH'(r_cnt);
    assign w_re_last  = (r_cnt == {1'b0, r_len});

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_ret_nxt = r_drain_ret;
        w_addr_nxt      = r_addr;
        w_len_nxt       = r_len;
        w_src_nxt       = r_src;
        w_cnt_nxt       = r_cnt;
        w_hdr_sent_nxt  = r_hdr_sent;
        w_we            = 1'b0;
        w_re            = 1'b0;
        w_hdr_push      = 1'b0;
        w_fsm_push      = 1'b0;
        w_fsm_data      = '0;
        w_fsm_last      = 1'b0;
        // Buffer occupancy once everything already committed has landed.
        w_occ           = 3'(w_count) + 3'(r_rd_valid) - 3'(w_pop);

        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_addr_nxt     = I_TDATA[MIC_ADDR_LSB +: 32];
                    w_len_nxt      = I_TDATA[MIC_LEN_LSB +: 8];
                    w_src_nxt      = I_TDATA[MIC_SRC_LSB +: 4];
                    w_cnt_nxt      = '0;
                    w_hdr_sent_nxt = 1'b0;
                    case (mic_cmd_e'(I_TDATA[MIC_CMD_LSB +: 2]))
                        CMD_WR_REQ: w_state_nxt = I_TLAST ? ST_WR_ACK : ST_WR_DATA;
                        CMD_RD_REQ: begin
                            w_state_nxt     = I_TLAST ? ST_RD_RUN : ST_DRAIN;
                            w_drain_ret_nxt = ST_RD_RUN;
                        end
                        default: begin
                            w_state_nxt     = I_TLAST ? ST_IDLE : ST_DRAIN;
                            w_drain_ret_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_WR_DATA: begin
                if (w_in_fire) begin
                    w_we      = 1'b1;
                    w_cnt_nxt = r_cnt + 9'd1;
                    if (I_TLAST) begin
                        w_state_nxt = ST_WR_ACK;
                    end else if (r_cnt == {1'b0, r_len}) begin
                        w_state_nxt     = ST_DRAIN;
                        w_drain_ret_nxt = ST_WR_ACK;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_in_fire && I_TLAST) w_state_nxt = r_drain_ret;
            end
            ST_WR_ACK: begin
                if (w_can_push) begin
                    w_fsm_push  = 1'b1;
                    w_fsm_data  = mic_build_hdr(r_addr, r_len, CMD_WR_ACK, r_src);
                    w_fsm_last  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_RUN: begin
                w_hdr_push = !r_hdr_sent && w_can_push;
                if (w_hdr_push) begin
                    w_fsm_push     = 1'b1;
                    w_fsm_data     = mic_build_hdr(r_addr, r_len, CMD_RD_RESP, r_src);
                    w_hdr_sent_nxt = 1'b1;
                end
                // Issue only when the returning word is guaranteed a buffer slot.
                if ((r_hdr_sent || w_hdr_push) && (r_cnt <= {1'b0, r_len}) &&
                    ((w_occ + 3'(w_hdr_push)) <= 3'd1)) begin
                    w_re      = 1'b1;
                    w_cnt_nxt = r_cnt + 9'd1;
                end
                if (r_rd_valid && r_rd_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drain_ret <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_src       <= '0;
            r_cnt       <= '0;
            r_hdr_sent  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_ret <= w_drain_ret_nxt;
            r_addr      <= w_addr_nxt;
            r_len       <= w_len_nxt;
            r_src       <= w_src_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hdr_sent  <= w_hdr_sent_nxt;
            r_rd_valid  <= w_re;
            r_rd_last   <= w_re && w_re_last;
        end
    end

    // SRAM contents survive reset; write and read never coincide.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_mem_addr] <= I_TDATA;
        if (w_re) r_rdata <= r_mem[w_mem_addr];
    end

    assign w_push      = r_rd_valid || w_fsm_push;
    assign w_push_data = r_rd_valid ? r_rdata   : w_fsm_data;
    assign w_push_last = r_rd_valid ? r_rd_last : w_fsm_last;

    mic_skid2 u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_last  (w_push_last),
        .i_ready (O_TREADY),
        .o_valid (O_TVALID),
        .o_data  (O_TDATA),
        .o_last  (O_TLAST),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_mic_sram_completer.sv
// Directed bench for mic_sram_completer: write/read bursts, stalls, wrap,
// short/long write packets, malformed commands and mid-burst reset.
module tb_mic_sram_completer;

    logic        clk = 1'b0;
    logic        reset;
    logic        I_TVALID;
    logic        I_TREADY;
    logic [63:0] I_TDATA;
    logic        I_TLAST;
    logic        O_TVALID;
    logic        O_TREADY;
    logic [63:0] O_TDATA;
    logic        O_TLAST;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] tx_d [16];
    int          tx_wait_max;
    logic [63:0] rx_d [16];
    logic        rx_l [16];
    int          rx_w [16];
    bit          rx_unstable;

    always #5 clk = ~clk;

    mic_sram_completer #(.ADDR_WIDTH(10), .INIT_FILE("")) dut (
        .clk      (clk),
        .reset    (reset),
        .I_TVALID (I_TVALID),
        .I_TREADY (I_TREADY),
        .I_TDATA  (I_TDATA),
        .I_TLAST  (I_TLAST),
        .O_TVALID (O_TVALID),
        .O_TREADY (O_TREADY),
        .O_TDATA  (O_TDATA),
        .O_TLAST  (O_TLAST)
    );

    // Drives tx_d[0..n-1] as one packet, TLAST on the final beat.
    task automatic send_pkt(input int n);
        int waits;
        tx_wait_max = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            I_TVALID = 1'b1;
            I_TDATA  = tx_d[i];
            I_TLAST  = (i == n - 1);
            waits    = 0;
            while (I_TREADY !== 1'b1 && waits < 100) begin
                @(negedge clk);
                waits++;
            end
            if (waits >= 100) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout beat=%0d got=no_ready exp=ready", i);
            end else begin
                @(posedge clk);
            end
            if (waits > tx_wait_max) tx_wait_max = waits;
            #1;
            I_TVALID = 1'b0;
            I_TLAST  = 1'b0;
        end
    endtask

    // Collects n response beats; rnd selects a random 50% O_TREADY pattern.
    task automatic recv_pkt(input bit rnd, input int n);
        logic [64:0] held;
        bit          have_held;
        rx_unstable = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_w[i] = 0;
            rx_d[i] = '0;
            rx_l[i] = 1'b0;
            have_held = 1'b0;
            forever begin
                @(negedge clk);
                O_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (have_held && (O_TVALID !== 1'b1 || {O_TLAST, O_TDATA} !== held))
                    rx_unstable = 1'b1;
                if (O_TVALID === 1'b1 && O_TREADY) begin
                    rx_d[i] = O_TDATA;
                    rx_l[i] = O_TLAST;
                    break;
                end
                if (O_TVALID === 1'b1) begin
                    held      = {O_TLAST, O_TDATA};
                    have_held = 1'b1;
                end
                rx_w[i]++;
                if (rx_w[i] >= 200) begin
                    n_vec++; n_err++;
                    $display("FAIL recv_timeout beat=%0d got=no_valid exp=valid", i);
                    break;
                end
            end
        end
        @(negedge clk);
        O_TREADY = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; I_TVALID = 1'b0; I_TDATA = '0; I_TLAST = 1'b0; O_TREADY = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({I_TREADY, O_TVALID, O_TLAST} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=000", {I_TREADY, O_TVALID, O_TLAST});
        end
        n_vec++;
        if (O_TDATA !== 64'h0) begin
            n_err++; $display("FAIL reset_tdata got=%h exp=0", O_TDATA);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (I_TREADY !== 1'b1) begin
            n_err++; $display("FAIL idle_ready got=%b exp=1", I_TREADY);
        end
    endtask

    task automatic test_write_burst();
        tx_d[0] = 64'h0000_5103_0000_0100;
        for (int i = 0; i < 4; i++) tx_d[i+1] = 64'hA0 + 64'(i);
        send_pkt(5);
        n_vec++;
        if (tx_wait_max !== 0) begin
            n_err++; $display("FAIL wr_back_to_back got=%0d exp=0", tx_wait_max);
        end
        recv_pkt(1'b0, 1);
        n_vec++;
        if (rx_d[0] !== 64'h0000_5303_0000_0100) begin
            n_err++; $display("FAIL wr_ack_hdr got=%h exp=%h", rx_d[0], 64'h0000_5303_0000_0100);
        end
        n_vec++;
        if (rx_l[0] !== 1'b1) begin
            n_err++; $display("FAIL wr_ack_last got=%b exp=1", rx_l[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (O_TVALID !== 1'b0) begin
                n_err++; $display("FAIL wr_ack_single got=%b exp=0", O_TVALID);
            end
        end
    endtask

    task automatic test_read_stream();
        tx_d[0] = 64'h0000_5003_0000_0100;
        send_pkt(1);
        recv_pkt(1'b0, 5);
        n_vec++;
        if (rx_d[0] !== 64'h0000_5203_0000_0100 || rx_l[0] !== 1'b0) begin
            n_err++; $display("FAIL rd_hdr got=%h/%b exp=%h/0", rx_d[0], rx_l[0], 64'h0000_5203_0000_0100);
        end
        n_vec++;
        if (rx_w[0] !== 1) begin
            n_err++; $display("FAIL rd_hdr_latency got=%0d exp=1", rx_w[0]);
        end
        for (int i = 1; i < 5; i++) begin
            n_vec++;
            if (rx_d[i] !== 64'hA0 + 64'(i - 1) || rx_l[i] !== (i == 4)) begin
                n_err++;
                $display("FAIL rd_data[%0d] got=%h/%b exp=%h/%b", i, rx_d[i], rx_l[i], 64'hA0 + 64'(i - 1), i == 4);
            end
            n_vec++;
            if (rx_w[i] !== 0) begin
                n_err++; $display("FAIL rd_gap[%0d] got=%0d exp=0", i, rx_w[i]);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (O_TVALID !== 1'b0) begin
            n_err++; $display("FAIL rd_no_extra got=%b exp=0", O_TVALID);
        end
    endtask

    task automatic test_read_stall();
        for (int rep = 0; rep < 3; rep++) begin
            tx_d[0] = 64'h0000_5003_0000_0100;
            send_pkt(1);
            recv_pkt(1'b1, 5);
            n_vec++;
            if (rx_d[0] !== 64'h0000_5203_0000_0100 || rx_l[0] !== 1'b0) begin
                n_err++; $display("FAIL stall_hdr got=%h/%b exp=%h/0", rx_d[0], rx_l[0], 64'h0000_5203_0000_0100);
            end
            for (int i = 1; i < 5; i++) begin
                n_vec++;
                if (rx_d[i] !== 64'hA0 + 64'(i - 1) || rx_l[i] !== (i == 4)) begin
                    n_err++;
                    $display("FAIL stall_data[%0d] got=%h/%b exp=%h/%b", i, rx_d[i], rx_l[i], 64'hA0 + 64'(i - 1), i == 4);
                end
            end
            n_vec++;
            if (rx_unstable !== 1'b0) begin
                n_err++; $display("FAIL stall_stable got=%b exp=0", rx_unstable);
            end
            repeat (2) @(negedge clk);
            n_vec++;
            if (O_TVALID !== 1'b0) begin
                n_err++; $display("FAIL stall_no_extra got=%b exp=0", O_TVALID);
            end
        end
    endtask

    task automatic test_wrap();
        tx_d[0] = 64'h0000_2101_0000_1FF8;
        tx_d[1] = 64'h11;
        tx_d[2] = 64'h22;
        send_pkt(3);
        recv_pkt(1'b0, 1);
        n_vec++;
        if (rx_d[0] !== 64'h0000_2301_0000_1FF8 || rx_l[0] !== 1'b1) begin
            n_err++; $display("FAIL wrap_ack got=%h/%b exp=%h/1", rx_d[0], rx_l[0], 64'h0000_2301_0000_1FF8);
        end
        tx_d[0] = 64'h0000_2000_0000_0000;
        send_pkt(1);
        recv_pkt(1'b0, 2);
        n_vec++;
        if (rx_d[0] !== 64'h0000_2200_0000_0000 || rx_d[1] !== 64'h22 || rx_l[1] !== 1'b1) begin
            n_err++; $display("FAIL wrap_word0 got=%h,%h/%b exp=%h,22/1", rx_d[0], rx_d[1], rx_l[1], 64'h0000_2200_0000_0000);
        end
        tx_d[0] = 64'h0000_2000_0000_1FF8;
        send_pkt(1);
        recv_pkt(1'b0, 2);
        n_vec++;
        if (rx_d[0] !== 64'h0000_2200_0000_1FF8 || rx_d[1] !== 64'h11 || rx_l[1] !== 1'b1) begin
            n_err++; $display("FAIL wrap_last_word got=%h,%h/%b exp=%h,11/1", rx_d[0], rx_d[1], rx_l[1], 64'h0000_2200_0000_1FF8);
        end
    endtask

    task automatic test_early_last();
        logic [63:0] exp_d [4];
        exp_d[0] = 64'hC0; exp_d[1] = 64'hC1; exp_d[2] = 64'hB2; exp_d[3] = 64'hB3;
        tx_d[0] = 64'h0000_1103_0000_0200;
        for (int i = 0; i < 4; i++) tx_d[i+1] = 64'hB0 + 64'(i);
        send_pkt(5);
        recv_pkt(1'b0, 1);
        tx_d[1] = 64'hC0;
        tx_d[2] = 64'hC1;
        send_pkt(3);
        recv_pkt(1'b0, 1);
        n_vec++;
        if (rx_d[0] !== 64'h0000_1303_0000_0200 || rx_l[0] !== 1'b1) begin
            n_err++; $display("FAIL early_ack got=%h/%b exp=%h/1", rx_d[0], rx_l[0], 64'h0000_1303_0000_0200);
        end
        tx_d[0] = 64'h0000_1003_0000_0200;
        send_pkt(1);
        recv_pkt(1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rx_d[i+1] !== exp_d[i]) begin
                n_err++; $display("FAIL early_data[%0d] got=%h exp=%h", i, rx_d[i+1], exp_d[i]);
            end
        end
    endtask

    task automatic test_len0_extra();
        tx_d[0] = 64'h0000_3100_0000_0300;
        tx_d[1] = 64'hD0; tx_d[2] = 64'hD1; tx_d[3] = 64'hD2;
        send_pkt(4);
        recv_pkt(1'b0, 1);
        n_vec++;
        if (rx_d[0] !== 64'h0000_3300_0000_0300 || rx_l[0] !== 1'b1) begin
            n_err++; $display("FAIL len0_ack got=%h/%b exp=%h/1", rx_d[0], rx_l[0], 64'h0000_3300_0000_0300);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (O_TVALID !== 1'b0) begin
            n_err++; $display("FAIL len0_single_ack got=%b exp=0", O_TVALID);
        end
        tx_d[0] = 64'h0000_3000_0000_0300;
        send_pkt(1);
        recv_pkt(1'b0, 2);
        n_vec++;
        if (rx_d[1] !== 64'hD0 || rx_l[1] !== 1'b1) begin
            n_err++; $display("FAIL len0_data got=%h/%b exp=d0/1", rx_d[1], rx_l[1]);
        end
    endtask

    task automatic test_drain_and_bad_cmd();
        tx_d[0] = 64'h0000_4200_0000_0000;
        send_pkt(1);
        tx_d[0] = 64'h0000_4300_0000_0000;
        tx_d[1] = 64'hBAD;
        send_pkt(2);
        repeat (4) @(negedge clk);
        n_vec++;
        if (O_TVALID !== 1'b0 || I_TREADY !== 1'b1) begin
            n_err++; $display("FAIL bad_cmd_silent got=%b%b exp=01", O_TVALID, I_TREADY);
        end
        tx_d[0] = 64'h0000_4003_0000_0100;
        tx_d[1] = 64'hDEAD;
        send_pkt(2);
        recv_pkt(1'b0, 5);
        n_vec++;
        if (rx_d[0] !== 64'h0000_4203_0000_0100) begin
            n_err++; $display("FAIL drain_rd_hdr got=%h exp=%h", rx_d[0], 64'h0000_4203_0000_0100);
        end
        n_vec++;
        if (rx_d[4] !== 64'hA3 || rx_l[4] !== 1'b1 || rx_d[1] !== 64'hA0) begin
            n_err++; $display("FAIL drain_rd_data got=%h..%h/%b exp=a0..a3/1", rx_d[1], rx_d[4], rx_l[4]);
        end
    endtask

    task automatic test_reset_mid();
        tx_d[0] = 64'h0000_6003_0000_0100;
        send_pkt(1);
        recv_pkt(1'b0, 2);
        n_vec++;
        if (rx_d[1] !== 64'hA0) begin
            n_err++; $display("FAIL rstmid_first got=%h exp=a0", rx_d[1]);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (O_TVALID !== 1'b0 || I_TREADY !== 1'b0) begin
            n_err++; $display("FAIL rstmid_quiet got=%b%b exp=00", O_TVALID, I_TREADY);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (O_TVALID !== 1'b0 || I_TREADY !== 1'b1) begin
            n_err++; $display("FAIL rstmid_idle got=%b%b exp=01", O_TVALID, I_TREADY);
        end
        tx_d[0] = 64'h0000_6003_0000_0100;
        send_pkt(1);
        recv_pkt(1'b0, 5);
        n_vec++;
        if (rx_d[0] !== 64'h0000_6203_0000_0100) begin
            n_err++; $display("FAIL rstmid_hdr got=%h exp=%h", rx_d[0], 64'h0000_6203_0000_0100);
        end
        for (int i = 1; i < 5; i++) begin
            n_vec++;
            if (rx_d[i] !== 64'hA0 + 64'(i - 1) || rx_l[i] !== (i == 4)) begin
                n_err++;
                $display("FAIL rstmid_data[%0d] got=%h/%b exp=%h/%b", i, rx_d[i], rx_l[i], 64'hA0 + 64'(i - 1), i == 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_stream();
        test_read_stall();
        test_wrap();
        test_early_last();
        test_len0_extra();
        test_drain_and_bad_cmd();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
